// File: rtl/wb_master_pkg.sv
// wb_master_pkg: FSM states and response status codes shared by the Wishbone register master.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_ERR     = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_reg_master.sv
// wb_reg_master: turns one command at a time into a Wishbone classic cycle and
// holds the response (OK / ERR / TIMEOUT) until it is consumed.
module wb_reg_master
    import wb_master_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W/8-1:0] cmd_sel,
    input  logic [DATA_W-1:0]   cmd_dat,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic [1:0]          rsp_status,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W/8-1:0] sel_q, sel_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic [1:0]          stat_q, stat_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            rdat_q  <= '0;
            stat_q  <= STAT_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Termination sources are only looked at in BUS; err outranks ack, either outranks timeout.
    assign done = wb_err_i || wb_ack_i || (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                adr_d   = cmd_adr;
                sel_d   = cmd_sel;
                we_d    = cmd_we;
                dat_d   = cmd_we ? cmd_dat : '0;
                cyc_d   = 1'b1;
                cnt_d   = '0;
                state_d = BUS;
            end
            BUS: if (done) begin
                cyc_d   = 1'b0;
                stat_d  = wb_err_i ? STAT_ERR : wb_ack_i ? STAT_OK : STAT_TIMEOUT;
                rdat_d  = (wb_ack_i && !wb_err_i && !we_q) ? wb_dat_i : '0;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_dat    = rdat_q;
    assign rsp_status = stat_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_sel_o   = sel_q;
    assign wb_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_reg_master.sv
// tb_wb_reg_master: scoreboard bench; expected responses are queued at command time
// and compared when the master presents them.
module tb_wb_reg_master;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] dat;
        int          stb;
    } rsp_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [9:0]  cmd_adr = '0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [9:0]  wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o, wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

    rsp_t sb[$];
    int   n_vec = 0, n_err = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_reg_master #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ack_at < 0 means the slave never answers; the cycle must then time out.
    task automatic run_cmd(input logic we, input logic [9:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input int ack_at, input logic err,
                           input logic [31:0] rdat, input int hold);
        rsp_t e;
        int   k;
        e.status = (ack_at < 0) ? 2'b10 : err ? 2'b01 : 2'b00;
        e.dat    = (ack_at >= 0 && !err && !we) ? rdat : 32'h0;
        e.stb    = (ack_at < 0) ? 8 : ack_at + 1;
        sb.push_back(e);
        @(negedge wb_clk_i);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0; cmd_adr = 10'($urandom); cmd_sel = 4'($urandom); cmd_dat = $urandom;
        k = 0;
        while (wb_stb_o && k < 40) begin
            chk("wb_bus_fields", {wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o},
                {1'b1, we, adr, sel, we ? dat : 32'h0});
            wb_ack_i = (k == ack_at);
            wb_err_i = err && (k == ack_at);
            wb_dat_i = (k == ack_at) ? rdat : $urandom;
            k++;
            @(negedge wb_clk_i);
        end
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = $urandom;
        for (int i = 0; i < hold; i++) begin
            chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_hold_data", {rsp_status, rsp_dat}, {sb[0].status, sb[0].dat});
            chk("rsp_hold_cmd_ready", 64'(cmd_ready), 64'd0);
            cmd_valid = 1'b1;
            @(negedge wb_clk_i);
            chk("rsp_hold_no_cyc", 64'(wb_cyc_o), 64'd0);
        end
        cmd_valid = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        e = sb.pop_front();
        chk("stb_cycles", 64'(k), 64'(e.stb));
        chk("rsp_status", 64'(rsp_status), 64'(e.status));
        chk("rsp_dat", 64'(rsp_dat), 64'(e.dat));
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #1;
        chk("reset_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
                              rsp_valid, rsp_dat, rsp_status}, 64'd0);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        run_cmd(1'b1, 10'h004, 4'hF, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);
        run_cmd(1'b0, 10'h040, 4'hF, 32'h0, 3, 1'b0, 32'h12345678, 0);
        run_cmd(1'b0, 10'h080, 4'h3, 32'h0, 1, 1'b1, 32'hCAFEF00D, 0);
        run_cmd(1'b0, 10'h0C0, 4'hF, 32'h0, -1, 1'b0, 32'h0, 0);
        run_cmd(1'b0, 10'h100, 4'hF, 32'h0, 0, 1'b0, 32'hA5A55A5A, 5);
        run_cmd(1'b1, 10'h3FC, 4'h0, 32'h11223344, 2, 1'b0, 32'h0, 0);

        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 10'h200; cmd_sel = 4'hF;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        chk("pre_reset_stb", 64'(wb_stb_o), 64'd1);
        #2 wb_rst_i = 1'b1;
        #1 chk("async_reset_cyc_stb", {wb_cyc_o, wb_stb_o}, 64'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            chk("reset_no_rsp", 64'(rsp_valid), 64'd0);
        end
        wb_rst_i = 1'b0; wb_ack_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge wb_clk_i);
            chk("after_reset_idle", {rsp_valid, wb_cyc_o, cmd_ready}, 64'd1);
        end

        for (int i = 0; i < 4; i++)
            run_cmd(1'($urandom), 10'($urandom), 4'($urandom), $urandom,
                    int'($urandom_range(0, 5)), 1'($urandom_range(0, 3) == 0), $urandom,
                    int'($urandom_range(0, 2)));

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
